hi_sim_tx_scheduler: RTL



---
 rtl/hi_sim_tx_scheduler.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/hi_sim_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : hi_sim_tx_scheduler
// Description : ISO 14443-A tag-simulator transmit sequencer. Byte FIFO,
//               frame-delay wait after reader EOF, then SOF / Manchester data
//               / EOF on an fc/16 subcarrier load-modulation output.
//               Optional odd parity per byte: define HI_SIM_TX_PARITY_EN.
// Revision    : 1.0  initial release
// ============================================================================
module hi_sim_tx_scheduler #(
    parameter int DEPTH = 32,
    parameter int FDT_W = 16
) (
    input  logic                     ck_1356meg,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     clr,
    input  logic                     arm,
    input  logic                     trigger,
    input  logic [FDT_W-1:0]         fdt,
    output logic                     mod_out,
    output logic                     busy,
    output logic                     done,
    output logic                     armed,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow
);

    localparam int             C_AW   = $clog2(DEPTH);
    localparam logic [C_AW:0]  C_FULL = (C_AW+1)'(DEPTH);
`ifdef HI_SIM_TX_PARITY_EN
    localparam logic [3:0]     C_LAST_BIT = 4'd8;
`else
    localparam logic [3:0]     C_LAST_BIT = 4'd7;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_DELAY = 3'd2,
        S_SOF   = 3'd3,
        S_DATA  = 3'd4,
        S_EOF   = 3'd5
    } state_t;

    // FIFO storage and bookkeeping
    logic [7:0]       r_mem [DEPTH];
    logic [C_AW-1:0]  r_wr_ptr, r_rd_ptr;
    logic [C_AW:0]    r_count;
    logic             r_overflow;

    // Sequencer state
    state_t           r_state, w_state_nxt;
    logic [6:0]       r_phase, w_phase_nxt;
    logic [3:0]       r_bit_idx, w_bit_idx_nxt;
    logic [8:0]       r_shift, w_shift_nxt;
    logic [FDT_W-1:0] r_delay, w_delay_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             r_mod, w_mod_nxt;

    logic             w_pop, w_full, w_wr_ok;
    logic [7:0]       w_head;
    logic [8:0]       w_load;
    logic [FDT_W-1:0] w_delay_dec;
    logic             w_bitval, w_active;

    assign w_head      = r_mem[r_rd_ptr];
    assign w_full      = (r_count == C_FULL);
    assign w_wr_ok     = wr_en && (!w_full || w_pop);
    assign w_delay_dec = r_delay - 1'b1;
`ifdef HI_SIM_TX_PARITY_EN
    // Odd parity: bit is 1 when the byte holds an even number of ones
    assign w_load = {~^w_head, w_head};
`else
    assign w_load = {1'b0, w_head};
`endif

    // Next-state, datapath and look-ahead modulation for the next cycle
    always_comb begin
        w_state_nxt   = r_state;
        w_phase_nxt   = r_phase;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_delay_nxt   = r_delay;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_pop         = 1'b0;
        if (clr) begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            w_phase_nxt = 7'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (arm && (r_count != '0)) w_state_nxt = S_ARMED;
                end
                S_ARMED: begin
                    if (trigger) begin
                        w_delay_nxt = fdt;
                        w_busy_nxt  = 1'b1;
                        w_phase_nxt = 7'd0;
                        // A zero delay starts SOF on the very next cycle
                        w_state_nxt = (fdt == '0) ? S_SOF : S_DELAY;
                    end
                end
                S_DELAY: begin
                    w_delay_nxt = w_delay_dec;
                    if (w_delay_dec == '0) begin
                        w_state_nxt = S_SOF;
                        w_phase_nxt = 7'd0;
                    end
                end
                S_SOF: begin
                    w_phase_nxt = r_phase + 7'd1;
                    if (r_phase == 7'd127) begin
                        w_bit_idx_nxt = 4'd0;
                        if (r_count != '0) begin
                            w_state_nxt = S_DATA;
                            w_shift_nxt = w_load;
                        end else begin
                            w_state_nxt = S_EOF;
                        end
                    end
                end
                S_DATA: begin
                    w_phase_nxt = r_phase + 7'd1;
                    // Byte was latched one cycle early; retire it from the FIFO now
                    if ((r_phase == 7'd0) && (r_bit_idx == 4'd0)) w_pop = 1'b1;
                    if (r_phase == 7'd127) begin
                        if (r_bit_idx == C_LAST_BIT) begin
                            w_bit_idx_nxt = 4'd0;
                            if (r_count != '0) w_shift_nxt = w_load;
                            else               w_state_nxt = S_EOF;
                        end else begin
                            w_bit_idx_nxt = r_bit_idx + 4'd1;
                            w_shift_nxt   = r_shift >> 1;
                        end
                    end
                end
                S_EOF: begin
                    w_phase_nxt = r_phase + 7'd1;
                    if (r_phase == 7'd127) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                        w_busy_nxt  = 1'b0;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
        // Modulation is computed from next-cycle values so the register has no lag
        w_active  = (w_state_nxt == S_SOF) || (w_state_nxt == S_DATA);
        w_bitval  = (w_state_nxt == S_SOF) ? 1'b1 : w_shift_nxt[0];
        w_mod_nxt = w_active && (w_phase_nxt[6] != w_bitval) && !w_phase_nxt[3];
    end

    // Sequencer state register
    always_ff @(posedge ck_1356meg or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_phase   <= 7'd0;
            r_bit_idx <= 4'd0;
            r_shift   <= 9'd0;
            r_delay   <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_mod     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_phase   <= w_phase_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_delay   <= w_delay_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_mod     <= w_mod_nxt;
        end
    end

    // FIFO pointers, occupancy and sticky overflow; clr flushes everything
    always_ff @(posedge ck_1356meg or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (clr) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_wr_ok && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_wr_ok && w_pop) r_count <= r_count - 1'b1;
            if (wr_en && !w_wr_ok) r_overflow <= 1'b1;
        end
    end

    // FIFO storage write port (data needs no reset)
    always_ff @(posedge ck_1356meg) begin
        if (w_wr_ok && !clr) r_mem[r_wr_ptr] <= wr_data;
    end

    assign mod_out  = r_mod;
    assign busy     = r_busy;
    assign done     = r_done;
    assign armed    = (r_state == S_ARMED);
    assign level    = r_count;
    assign overflow = r_overflow;

endmodule
`default_nettype wire
